// File: rtl/pit_pkg.sv
// Shared definitions for one 8253-style timer channel: state and mode
// encodings, byte-format codes and the default counter width.
package pit_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        ARMED     = 2'd2,
        COUNT     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_OS   = 2'd1,
        MODE_P1   = 2'd2,
        MODE_P2   = 2'd3
    } mode_e;

    localparam logic [1:0] RW_LSB = 2'b01;
    localparam logic [1:0] RW_MSB = 2'b10;
    localparam logic [1:0] RW_LM  = 2'b11;

endpackage

// File: rtl/pit_byte_seq.sv
// Byte sequencing for count writes and read-back, plus the output latch
// and its release after the last byte of the current format is read.
module pit_byte_seq
    import pit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [1:0]  rw,
    input  logic        wr,
    input  logic        latch,
    input  logic        rd,
    input  logic [15:0] ce,
    output logic        wr_first,
    output logic        wr_done,
    output logic [7:0]  rd_data
);

    logic        wr_tog_q, wr_tog_d;
    logic        rd_tog_q, rd_tog_d;
    logic        latched_q, latched_d;
    logic [15:0] ol_q, ol_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [15:0] src;
    logic        latch_now;
    logic        rd_hi;
    logic        rd_last;

    assign wr_first  = !wr_tog_q;
    assign wr_done   = wr && ((rw != RW_LM) || wr_tog_q);
    assign latch_now = latch && !latched_q;
    // A latch in the same cycle as rd captures ce, so reading live ce here
    // already returns the freshly latched value.
    assign src       = latched_q ? ol_q : ce;
    assign rd_hi     = (rw == RW_MSB) || ((rw == RW_LM) && rd_tog_q);
    assign rd_last   = (rw != RW_LM) || rd_tog_q;
    assign rd_data   = rd_data_q;

    always_comb begin
        wr_tog_d  = wr_tog_q;
        rd_tog_d  = rd_tog_q;
        latched_d = latched_q;
        ol_d      = ol_q;
        rd_data_d = rd_data_q;

        if (latch_now) begin
            ol_d      = ce;
            latched_d = 1'b1;
        end

        if (wr && (rw == RW_LM)) begin
            wr_tog_d = !wr_tog_q;
        end

        if (rd) begin
            rd_data_d = rd_hi ? src[15:8] : src[7:0];
            if (rw == RW_LM) begin
                rd_tog_d = !rd_tog_q;
            end
            if (rd_last) begin
                latched_d = 1'b0;
            end
        end

        if (clr) begin
            wr_tog_d  = 1'b0;
            rd_tog_d  = 1'b0;
            latched_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_tog_q  <= 1'b0;
            rd_tog_q  <= 1'b0;
            latched_q <= 1'b0;
            ol_q      <= '0;
            rd_data_q <= 8'h00;
        end else begin
            wr_tog_q  <= wr_tog_d;
            rd_tog_q  <= rd_tog_d;
            latched_q <= latched_d;
            ol_q      <= ol_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/pit_counter.sv
// One timer channel: count FSM, 16-bit down-counter and per-mode OUT logic.
//
//   state     | meaning
//   IDLE      | not configured since reset
//   WAIT_LOAD | configured, waiting for the full count to be written
//   ARMED     | count ready, next tick copies cr into ce
//   COUNT     | counting on ticks
module pit_counter
    import pit_pkg::*;
#(
    parameter int CNT_W      = pit_pkg::DEF_CNT_W,
    parameter int MIN_PCOUNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       gate,
    input  logic       cfg_wr,
    input  logic       mode_os,
    input  logic       mode_p1,
    input  logic       mode_p2,
    input  logic [1:0] rw,
    input  logic       data_wr,
    input  logic [7:0] data_in,
    input  logic       latch,
    input  logic       rd,
    output logic [7:0] rd_data,
    output logic       out
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [1:0]       rw_q, rw_d;
    logic [CNT_W-1:0] cr_q, cr_d;
    logic [CNT_W-1:0] ce_q, ce_d;
    logic             out_q, out_d;
    logic             gate_q;

    logic             cfg_acc;
    logic             wr_acc;
    logic             wr_first;
    logic             wr_done;
    logic             p_mode;
    logic             arm;
    logic [CNT_W-1:0] eff_cr;
    logic [CNT_W-1:0] p2_hi;
    logic [CNT_W-1:0] p2_lo;

    assign cfg_acc = cfg_wr && (rw != 2'b00);
    assign wr_acc  = data_wr && !cfg_wr && (state_q != IDLE);
    assign p_mode  = (mode_q == MODE_P1) || (mode_q == MODE_P2);
    assign eff_cr  = (p_mode && (cr_q != '0) && (cr_q < CNT_W'(MIN_PCOUNT)))
                     ? CNT_W'(MIN_PCOUNT) : cr_q;
    // P2 counts by two; each half reloads with twice its tick length, so an
    // odd N gets the extra tick in the high half.
    assign p2_hi   = eff_cr + {{(CNT_W-1){1'b0}}, eff_cr[0]};
    assign p2_lo   = {eff_cr[CNT_W-1:1], 1'b0};
    assign out     = out_q;

    pit_byte_seq u_byte_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (cfg_acc),
        .rw       (rw_q),
        .wr       (wr_acc),
        .latch    (latch),
        .rd       (rd),
        .ce       (ce_q),
        .wr_first (wr_first),
        .wr_done  (wr_done),
        .rd_data  (rd_data)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rw_d    = rw_q;
        cr_d    = cr_q;
        ce_d    = ce_q;
        out_d   = out_q;

        // A gate rising edge in P1/P2 behaves like a fresh arm.
        arm = (state_q == ARMED) ||
              (p_mode && (state_q == COUNT) && gate && !gate_q);
        if (arm) begin
            state_d = ARMED;
        end

        if (tick) begin
            if (arm) begin
                state_d = COUNT;
                case (mode_q)
                    MODE_P1: begin
                        ce_d  = eff_cr;
                        out_d = 1'b1;
                    end
                    MODE_P2: begin
                        ce_d  = p2_hi;
                        out_d = 1'b1;
                    end
                    default: ce_d = cr_q;
                endcase
            end else if ((state_q == COUNT) && gate) begin
                case (mode_q)
                    MODE_OS: begin
                        ce_d = ce_q - CNT_W'(1);
                        if (ce_q == CNT_W'(1)) begin
                            out_d = 1'b1;
                        end
                    end
                    MODE_P1: begin
                        if (ce_q == CNT_W'(1)) begin
                            ce_d  = eff_cr;
                            out_d = 1'b1;
                        end else begin
                            ce_d = ce_q - CNT_W'(1);
                            if (ce_q == CNT_W'(2)) begin
                                out_d = 1'b0;
                            end
                        end
                    end
                    MODE_P2: begin
                        if (ce_q == CNT_W'(2)) begin
                            ce_d  = out_q ? p2_lo : p2_hi;
                            out_d = !out_q;
                        end else begin
                            ce_d = ce_q - CNT_W'(2);
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (p_mode && !gate) begin
            out_d = 1'b1;
        end

        if (wr_acc) begin
            case (rw_q)
                RW_MSB:  cr_d = {data_in, 8'h00};
                RW_LM:   cr_d = wr_first ? {cr_q[15:8], data_in} : {data_in, cr_q[7:0]};
                default: cr_d = {8'h00, data_in};
            endcase
            if (wr_done) begin
                case (state_q)
                    WAIT_LOAD, ARMED: state_d = ARMED;
                    COUNT: begin
                        if (mode_q == MODE_OS) begin
                            state_d = ARMED;
                            out_d   = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (cfg_acc) begin
            state_d = WAIT_LOAD;
            rw_d    = rw;
            if (mode_os) begin
                mode_d = MODE_OS;
                out_d  = 1'b0;
            end else if (mode_p1) begin
                mode_d = MODE_P1;
                out_d  = 1'b1;
            end else if (mode_p2) begin
                mode_d = MODE_P2;
                out_d  = 1'b1;
            end else begin
                mode_d = MODE_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_NONE;
            rw_q    <= 2'b00;
            cr_q    <= '0;
            ce_q    <= '0;
            out_q   <= 1'b1;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rw_q    <= rw_d;
            cr_q    <= cr_d;
            ce_q    <= ce_d;
            out_q   <= out_d;
            gate_q  <= gate;
        end
    end

endmodule

// File: tb/tb_pit_counter.sv
// Directed bench for pit_counter: a per-cycle vector table for OS/P1/latch/
// collision behaviour, then hand-written P2 period, latch and reset sequences.
module tb_pit_counter;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       gate;
    logic       cfg_wr;
    logic       mode_os;
    logic       mode_p1;
    logic       mode_p2;
    logic [1:0] rw;
    logic       data_wr;
    logic [7:0] data_in;
    logic       latch;
    logic       rd;
    logic [7:0] rd_data;
    logic       out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       cfg;
        logic [2:0] md;
        logic [1:0] rwv;
        logic       wr;
        logic [7:0] d;
        logic       tk;
        logic       g;
        logic       lt;
        logic       rdv;
        logic       eo;
        logic       crd;
        logic [7:0] erd;
    } vec_t;

    vec_t vt[$];

    pit_counter dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .gate    (gate),
        .cfg_wr  (cfg_wr),
        .mode_os (mode_os),
        .mode_p1 (mode_p1),
        .mode_p2 (mode_p2),
        .rw      (rw),
        .data_wr (data_wr),
        .data_in (data_in),
        .latch   (latch),
        .rd      (rd),
        .rd_data (rd_data),
        .out     (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic [2:0] md, input logic [1:0] r,
                       input logic w, input logic [7:0] d, input logic t,
                       input logic g, input logic l, input logic rdv);
        cfg_wr = c;
        {mode_p2, mode_p1, mode_os} = md;
        rw      = r;
        data_wr = w;
        data_in = d;
        tick    = t;
        gate    = g;
        latch   = l;
        rd      = rdv;
        @(posedge clk);
        #1;
        cfg_wr  = 1'b0;
        data_wr = 1'b0;
        tick    = 1'b0;
        latch   = 1'b0;
        rd      = 1'b0;
    endtask

    task automatic tk();
        cyc(1'b0, 3'b000, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic add_v(input logic c, input logic [2:0] md, input logic [1:0] r,
                         input logic w, input logic [7:0] d, input logic t,
                         input logic g, input logic l, input logic rdv,
                         input logic eo, input logic crd, input logic [7:0] erd);
        vec_t v;
        v.cfg = c;  v.md = md; v.rwv = r;  v.wr = w;  v.d = d;    v.tk = t;
        v.g = g;    v.lt = l;  v.rdv = rdv; v.eo = eo; v.crd = crd; v.erd = erd;
        vt.push_back(v);
    endtask

    task automatic add_t(input logic g, input logic eo);
        add_v(1'b0, 3'b000, 2'b00, 1'b0, 8'h00, 1'b1, g, 1'b0, 1'b0, eo, 1'b0, 8'h00);
    endtask

    task automatic p2_run(input logic [15:0] n, input int periods);
        int   hi;
        int   lo;
        int   len;
        int   cnt;
        logic lvl;
        hi = (n == 16'h0000) ? 32768 : (int'(n) + 1) / 2;
        lo = (n == 16'h0000) ? 32768 : int'(n) / 2;
        cyc(1'b1, 3'b100, 2'b11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 2'b00, 1'b1, n[7:0], 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 2'b00, 1'b1, n[15:8], 1'b0, 1'b1, 1'b0, 1'b0);
        tk();
        chk($sformatf("p2 n=%0h load out", n), {15'b0, out}, 16'd1);
        for (int ph = 0; ph < 2 * periods; ph++) begin
            lvl = (ph % 2 == 0);
            len = lvl ? hi : lo;
            cnt = 1;
            while (cnt <= len) begin
                tk();
                if (out !== lvl) break;
                cnt++;
            end
            chk($sformatf("p2 n=%0h phase%0d len", n, ph), 16'(cnt), 16'(len));
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; gate = 1'b1; cfg_wr = 1'b0;
        mode_os = 1'b0; mode_p1 = 1'b0; mode_p2 = 1'b0; rw = 2'b00;
        data_wr = 1'b0; data_in = 8'h00; latch = 1'b0; rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", {15'b0, out}, 16'd1);
        chk("reset rd_data", {8'h00, rd_data}, 16'h0000);
        rst = 1'b0;

        // OS, LSB only, count 4
        add_v(1, 3'b001, 2'b01, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00);
        add_v(0, 3'b000, 2'b00, 1, 8'h04, 0, 1, 0, 0, 0, 0, 8'h00);
        add_t(1, 0); add_t(1, 0); add_t(1, 0); add_t(1, 0);
        add_t(1, 1); add_t(1, 1);
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 1, 0, 1, 1, 1, 8'hFF);
        add_t(1, 1); add_t(0, 1);
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 0, 0, 1, 1, 1, 8'hFE);
        // OS rewrite while counting drops out and re-arms
        add_v(0, 3'b000, 2'b00, 1, 8'h02, 0, 1, 0, 0, 0, 0, 8'h00);
        add_t(1, 0); add_t(1, 0); add_t(1, 1);
        // P1 with count 1 runs as 2
        add_v(1, 3'b010, 2'b01, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00);
        add_v(0, 3'b000, 2'b00, 1, 8'h01, 0, 1, 0, 0, 1, 0, 8'h00);
        add_t(1, 1); add_t(1, 0);
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00);
        add_t(1, 1); add_t(1, 0);
        // P1, LSB/MSB, count 3, gate drop while out low
        add_v(1, 3'b010, 2'b11, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00);
        add_v(0, 3'b000, 2'b00, 1, 8'h03, 0, 1, 0, 0, 1, 0, 8'h00);
        add_v(0, 3'b000, 2'b00, 1, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00);
        add_t(1, 1); add_t(1, 1); add_t(1, 0);
        add_t(1, 1); add_t(1, 1); add_t(1, 0);
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00);
        add_t(0, 1); add_t(0, 1);
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00);
        add_t(1, 1); add_t(1, 1); add_t(1, 0); add_t(1, 1);
        // latch together with rd, then MSB of latch, then live LSB
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 1, 1, 1, 1, 1, 8'h03);
        add_t(1, 1);
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 1, 0, 1, 1, 1, 8'h00);
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 1, 0, 1, 1, 1, 8'h02);
        // cfg_wr with data_wr: write dropped, stays in WAIT_LOAD
        add_v(1, 3'b001, 2'b01, 1, 8'h05, 0, 1, 0, 0, 0, 0, 8'h00);
        add_t(1, 0); add_t(1, 0);
        add_v(0, 3'b000, 2'b00, 0, 8'h00, 0, 1, 0, 1, 0, 1, 8'h02);
        add_v(0, 3'b000, 2'b00, 1, 8'h01, 0, 1, 0, 0, 0, 0, 8'h00);
        add_t(1, 0); add_t(1, 1);

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].cfg, vt[i].md, vt[i].rwv, vt[i].wr, vt[i].d,
                vt[i].tk, vt[i].g, vt[i].lt, vt[i].rdv);
            chk($sformatf("vec%0d out", i), {15'b0, out}, {15'b0, vt[i].eo});
            if (vt[i].crd) begin
                chk($sformatf("vec%0d rd_data", i), {8'h00, rd_data}, {8'h00, vt[i].erd});
            end
        end

        // P2 latch and read-back, cr=0x1234: ce hits 0x1200 on the 27th tick
        cyc(1'b1, 3'b100, 2'b11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 2'b00, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 2'b00, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (27) tk();
        cyc(1'b0, 3'b000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (10) tk();
        cyc(1'b0, 3'b000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("latch rd lsb", {8'h00, rd_data}, 16'h0000);
        cyc(1'b0, 3'b000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("latch rd msb", {8'h00, rd_data}, 16'h0012);
        cyc(1'b0, 3'b000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("live rd lsb", {8'h00, rd_data}, 16'h00EC);

        p2_run(16'd5, 2);
        p2_run(16'd4, 2);
        p2_run(16'h0000, 1);

        // reset in the middle of an OS count
        cyc(1'b1, 3'b001, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b000, 2'b00, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tk();
        chk("pre-reset out", {15'b0, out}, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset out", {15'b0, out}, 16'd1);
        chk("async reset rd_data", {8'h00, rd_data}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 3'b000, 2'b00, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tk();
        cyc(1'b0, 3'b000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("idle write ignored rd", {8'h00, rd_data}, 16'h0000);
        chk("idle write ignored out", {15'b0, out}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
